// File: rtl/sprites_line_store.sv
// Per-scanline sprite store: up to SLOTS sprites with tile rows,
// presenting the lowest-slot X match on a registered output.
module sprites_line_store #(
  parameter  int SLOTS = 10,
  parameter  int XW    = 8,
  parameter  int IDXW  = 6,
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ce,
  input  logic            clear,
  input  logic            alloc,
  input  logic [XW-1:0]   alloc_x,
  input  logic [IDXW-1:0] alloc_oam,
  output logic [SW:0]     count,
  output logic            full,
  output logic            overflow,
  input  logic            tile_save,
  input  logic [SW-1:0]   tile_slot,
  input  logic [7:0]      tile0_in,
  input  logic [7:0]      tile1_in,
  input  logic            pal_in,
  input  logic            prio_in,
  input  logic [2:0]      cgb_pal_in,
  input  logic [XW-1:0]   xpos,
  input  logic            ack,
  output logic            hit,
  output logic            hit_loaded,
  output logic [SW-1:0]   hit_slot,
  output logic [IDXW-1:0] hit_oam,
  output logic [7:0]      tile0_o,
  output logic [7:0]      tile1_o,
  output logic            pal_o,
  output logic            prio_o,
  output logic [2:0]      cgb_pal_o
);

  logic [XW-1:0]   x_q    [SLOTS];
  logic [XW-1:0]   x_d    [SLOTS];
  logic [IDXW-1:0] oam_q  [SLOTS];
  logic [IDXW-1:0] oam_d  [SLOTS];
  logic [7:0]      t0_q   [SLOTS];
  logic [7:0]      t0_d   [SLOTS];
  logic [7:0]      t1_q   [SLOTS];
  logic [7:0]      t1_d   [SLOTS];
  logic [2:0]      cgb_q  [SLOTS];
  logic [2:0]      cgb_d  [SLOTS];
  logic [SLOTS-1:0] pal_q, pal_d, prio_q, prio_d;

  logic [SLOTS-1:0] valid_q, valid_d;
  logic [SLOTS-1:0] loaded_q, loaded_d;
  logic [SLOTS-1:0] done_q, done_d;
  logic [SW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;

  logic            hit_q, hit_d;
  logic            hld_q, hld_d;
  logic [SW-1:0]   hslot_q, hslot_d;
  logic [IDXW-1:0] hoam_q, hoam_d;
  logic [7:0]      ot0_q, ot0_d;
  logic [7:0]      ot1_q, ot1_d;
  logic            opal_q, opal_d;
  logic            oprio_q, oprio_d;
  logic [2:0]      ocgb_q, ocgb_d;

  logic [SLOTS-1:0] m;
  logic [SW-1:0]    sel;
  logic             full_w;

  assign full_w = (count_q == (SW+1)'(SLOTS));

  // The slot consumed this edge is masked so it cannot re-present.
  always_comb begin
    m   = '0;
    sel = '0;
    for (int i = 0; i < SLOTS; i++) begin
      m[i] = valid_q[i] & ~done_q[i] & (x_q[i] == xpos)
           & ~(ack & hit_q & (hslot_q == SW'(i)));
    end
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (m[i]) sel = SW'(i);
    end
  end

  always_comb begin
    x_d      = x_q;
    oam_d    = oam_q;
    t0_d     = t0_q;
    t1_d     = t1_q;
    cgb_d    = cgb_q;
    pal_d    = pal_q;
    prio_d   = prio_q;
    valid_d  = valid_q;
    loaded_d = loaded_q;
    done_d   = done_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    hit_d    = hit_q;
    hld_d    = hld_q;
    hslot_d  = hslot_q;
    hoam_d   = hoam_q;
    ot0_d    = ot0_q;
    ot1_d    = ot1_q;
    opal_d   = opal_q;
    oprio_d  = oprio_q;
    ocgb_d   = ocgb_q;
    if (clear) begin
      valid_d  = '0;
      loaded_d = '0;
      done_d   = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      hit_d    = 1'b0;
      hld_d    = 1'b0;
    end else begin
      hit_d = |m;
      hld_d = 1'b0;
      if (|m) begin
        hld_d   = loaded_q[sel];
        hslot_d = sel;
        hoam_d  = oam_q[sel];
        ot0_d   = t0_q[sel];
        ot1_d   = t1_q[sel];
        opal_d  = pal_q[sel];
        oprio_d = prio_q[sel];
        ocgb_d  = cgb_q[sel];
      end
      if (alloc) begin
        if (full_w) begin
          ovf_d = 1'b1;
        end else begin
          for (int i = 0; i < SLOTS; i++) begin
            if (count_q == (SW+1)'(i)) begin
              x_d[i]      = alloc_x;
              oam_d[i]    = alloc_oam;
              valid_d[i]  = 1'b1;
              loaded_d[i] = 1'b0;
              done_d[i]   = 1'b0;
            end
          end
          count_d = count_q + 1'b1;
        end
      end
      // Runs after alloc so a same-slot tile write leaves loaded set.
      if (tile_save) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (tile_slot == SW'(i)) begin
            t0_d[i]     = tile0_in;
            t1_d[i]     = tile1_in;
            pal_d[i]    = pal_in;
            prio_d[i]   = prio_in;
            cgb_d[i]    = cgb_pal_in;
            loaded_d[i] = 1'b1;
          end
        end
      end
      if (ack && hit_q) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (hslot_q == SW'(i)) done_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && ce) begin
      x_q    <= x_d;
      oam_q  <= oam_d;
      t0_q   <= t0_d;
      t1_q   <= t1_d;
      cgb_q  <= cgb_d;
      pal_q  <= pal_d;
      prio_q <= prio_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q  <= '0;
      loaded_q <= '0;
      done_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      hit_q    <= 1'b0;
      hld_q    <= 1'b0;
      hslot_q  <= '0;
      hoam_q   <= '0;
      ot0_q    <= '0;
      ot1_q    <= '0;
      opal_q   <= 1'b0;
      oprio_q  <= 1'b0;
      ocgb_q   <= '0;
    end else if (ce) begin
      valid_q  <= valid_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      hit_q    <= hit_d;
      hld_q    <= hld_d;
      hslot_q  <= hslot_d;
      hoam_q   <= hoam_d;
      ot0_q    <= ot0_d;
      ot1_q    <= ot1_d;
      opal_q   <= opal_d;
      oprio_q  <= oprio_d;
      ocgb_q   <= ocgb_d;
    end
  end

  assign count      = count_q;
  assign full       = full_w;
  assign overflow   = ovf_q;
  assign hit        = hit_q;
  assign hit_loaded = hld_q;
  assign hit_slot   = hslot_q;
  assign hit_oam    = hoam_q;
  assign tile0_o    = ot0_q;
  assign tile1_o    = ot1_q;
  assign pal_o      = opal_q;
  assign prio_o     = oprio_q;
  assign cgb_pal_o  = ocgb_q;

endmodule

// File: tb/tb_sprites_line_store.sv
// Scoreboard bench for sprites_line_store against a slot-list
// reference model with directed and random stimulus.
module tb_sprites_line_store;

  localparam int SLOTS = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b0;
  logic       clear = 1'b0;
  logic       alloc = 1'b0;
  logic [7:0] alloc_x = '0;
  logic [5:0] alloc_oam = '0;
  logic [4:0] count;
  logic       full, overflow;
  logic       tile_save = 1'b0;
  logic [3:0] tile_slot = '0;
  logic [7:0] tile0_in = '0;
  logic [7:0] tile1_in = '0;
  logic       pal_in = 1'b0;
  logic       prio_in = 1'b0;
  logic [2:0] cgb_pal_in = '0;
  logic [7:0] xpos = '0;
  logic       ack = 1'b0;
  logic       hit, hit_loaded;
  logic [3:0] hit_slot;
  logic [5:0] hit_oam;
  logic [7:0] tile0_o, tile1_o;
  logic       pal_o, prio_o;
  logic [2:0] cgb_pal_o;

  sprites_line_store #(.SLOTS(SLOTS), .XW(8), .IDXW(6)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .clear(clear),
    .alloc(alloc), .alloc_x(alloc_x), .alloc_oam(alloc_oam),
    .count(count), .full(full), .overflow(overflow),
    .tile_save(tile_save), .tile_slot(tile_slot),
    .tile0_in(tile0_in), .tile1_in(tile1_in), .pal_in(pal_in),
    .prio_in(prio_in), .cgb_pal_in(cgb_pal_in), .xpos(xpos),
    .ack(ack), .hit(hit), .hit_loaded(hit_loaded),
    .hit_slot(hit_slot), .hit_oam(hit_oam), .tile0_o(tile0_o),
    .tile1_o(tile1_o), .pal_o(pal_o), .prio_o(prio_o),
    .cgb_pal_o(cgb_pal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [5:0] oam;
    logic [7:0] t0, t1;
    logic       pal, prio;
    logic [2:0] cgb;
    bit         valid, loaded, done;
  } slot_t;

  slot_t      sl[SLOTS];
  int         cnt = 0;
  bit         ovf = 0;
  bit         o_hit = 0, o_ld = 0;
  logic [3:0] o_slot = '0;
  logic [5:0] o_oam = '0;
  logic [7:0] o_t0 = '0, o_t1 = '0;
  logic       o_pal = 0, o_prio = 0;
  logic [2:0] o_cgb = '0;

  logic [39:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  function automatic logic [39:0] act_vec();
    return {hit, hit_loaded, hit_slot, hit_oam, tile0_o, tile1_o,
            pal_o, prio_o, cgb_pal_o, count, full, overflow};
  endfunction

  // Reference: sprites are a list in scan order; the first live one
  // at the current X, not just handed over, is shown next.
  task automatic model();
    int w;
    if (!reset_n) begin
      foreach (sl[i]) begin
        sl[i].valid = 0; sl[i].loaded = 0; sl[i].done = 0;
      end
      cnt = 0; ovf = 0; o_hit = 0; o_ld = 0; o_slot = '0;
      o_oam = '0; o_t0 = '0; o_t1 = '0; o_pal = 0; o_prio = 0;
      o_cgb = '0;
    end else if (ce) begin
      if (clear) begin
        foreach (sl[i]) begin
          sl[i].valid = 0; sl[i].loaded = 0; sl[i].done = 0;
        end
        cnt = 0; ovf = 0; o_hit = 0; o_ld = 0;
      end else begin
        w = -1;
        for (int i = 0; i < SLOTS; i++) begin
          if (w < 0 && sl[i].valid && !sl[i].done && sl[i].x == xpos
              && !(ack && o_hit && int'(o_slot) == i))
            w = i;
        end
        if (ack && o_hit) sl[o_slot].done = 1;
        if (w >= 0) begin
          o_hit = 1; o_ld = sl[w].loaded; o_slot = 4'(w);
          o_oam = sl[w].oam; o_t0 = sl[w].t0; o_t1 = sl[w].t1;
          o_pal = sl[w].pal; o_prio = sl[w].prio; o_cgb = sl[w].cgb;
        end else begin
          o_hit = 0; o_ld = 0;
        end
        if (alloc) begin
          if (cnt == SLOTS) ovf = 1;
          else begin
            sl[cnt].x = alloc_x; sl[cnt].oam = alloc_oam;
            sl[cnt].valid = 1; sl[cnt].loaded = 0; sl[cnt].done = 0;
            cnt++;
          end
        end
        if (tile_save && int'(tile_slot) < SLOTS) begin
          sl[tile_slot].t0 = tile0_in; sl[tile_slot].t1 = tile1_in;
          sl[tile_slot].pal = pal_in; sl[tile_slot].prio = prio_in;
          sl[tile_slot].cgb = cgb_pal_in; sl[tile_slot].loaded = 1;
        end
      end
    end
  endtask

  task automatic tick();
    model();
    exp_q.push_back({o_hit, o_ld, o_slot, o_oam, o_t0, o_t1, o_pal,
                     o_prio, o_cgb, 5'(cnt), cnt == SLOTS, ovf});
    @(posedge clk);
    #2;
    clear = 0; alloc = 0; tile_save = 0; ack = 0;
  endtask

  always @(posedge clk) begin
    logic [39:0] e;
    logic [39:0] a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_vec();
      n_checks++;
      if (a === e) n_pass++;
      else
        $display("FAIL check%0d t=%0t got=%h exp=%h", n_checks,
                 $time, a, e);
    end
  end

  task automatic do_alloc(input logic [7:0] x, input logic [5:0] o);
    alloc = 1; alloc_x = x; alloc_oam = o;
    tick();
  endtask

  initial begin
    foreach (sl[i]) sl[i] = '{default: '0};
    @(posedge clk);
    #2;
    reset_n = 0;
    tick();
    tick();
    reset_n = 1; ce = 1;
    for (int i = 0; i < 256; i++) begin
      xpos = 8'(i);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      tile_save = 1; tile_slot = 4'(i);
      tile0_in = 8'($urandom); tile1_in = 8'($urandom);
      pal_in = 1'($urandom); prio_in = 1'($urandom);
      cgb_pal_in = 3'($urandom);
      tick();
    end

    clear = 1; tick();
    xpos = 8'h00;
    do_alloc(8'h10, 6'd3);
    do_alloc(8'h20, 6'd7);
    tile_save = 1; tile_slot = 4'd1; tile0_in = 8'hA5;
    tile1_in = 8'h3C; pal_in = 1; prio_in = 0; cgb_pal_in = 3'd5;
    tick();
    xpos = 8'h20; tick(); tick();
    xpos = 8'h10; tick(); tick();

    clear = 1; tick();
    do_alloc(8'h30, 6'd1);
    do_alloc(8'h30, 6'd2);
    do_alloc(8'h30, 6'd4);
    xpos = 8'h30;
    for (int i = 0; i < 6; i++) begin
      ack = 1; tick();
    end

    clear = 1; tick();
    xpos = 8'h00;
    for (int i = 0; i < 11; i++) do_alloc(8'(8'h60 + i), 6'(i));
    xpos = 8'h69; tick(); tick();
    do_alloc(8'h77, 6'd33);
    xpos = 8'h6A; tick();
    clear = 1; tick();
    tick();

    clear = 1; alloc = 1; alloc_x = 8'h50; alloc_oam = 6'd9; tick();
    xpos = 8'h50; tick();
    do_alloc(8'h50, 6'd11);
    tick();
    reset_n = 0; tick();
    reset_n = 1; tick(); tick();

    do_alloc(8'h44, 6'd12);
    xpos = 8'h44; tick();
    ce = 0;
    for (int i = 0; i < 5; i++) begin
      xpos = 8'($urandom); alloc = 1; alloc_x = 8'h44;
      alloc_oam = 6'(i); tick();
    end
    ce = 1; xpos = 8'h44; tick(); tick();

    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 499) != 0);
      ce = ($urandom_range(0, 4) != 0);
      clear = ($urandom_range(0, 39) == 0);
      alloc = ($urandom_range(0, 3) == 0);
      alloc_x = 8'(8'h40 + $urandom_range(0, 3));
      alloc_oam = 6'($urandom);
      tile_save = ($urandom_range(0, 3) == 0);
      tile_slot = 4'($urandom);
      tile0_in = 8'($urandom); tile1_in = 8'($urandom);
      pal_in = 1'($urandom); prio_in = 1'($urandom);
      cgb_pal_in = 3'($urandom);
      xpos = 8'(8'h40 + $urandom_range(0, 4));
      ack = 1'($urandom);
      tick();
    end
    reset_n = 1; ce = 1;

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
